// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: forms byte address, handshakes with word memory, extends loads.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module lsu_unit #(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_re,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_misaligned,
  output logic [31:0]       exc_addr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_SKIP, S_EXC} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic [31:0] ldata_q, ldata_d;

  logic        accept;
  logic [31:0] byte_addr;
  logic        legal;
  logic        trap;
  logic [15:0] lane_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign byte_addr = req_base + req_imm;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_store;
      default:                legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap   = legal && (((req_funct3[1:0] == 2'b01) && byte_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (byte_addr[1:0] != 2'b00)));
  // Every access that is not trapped is already aligned, so the raw address doubles as exc_addr.
  assign addr_d = byte_addr;
`else
  assign trap = 1'b0;
  always_comb begin
    addr_d = byte_addr;
    if (req_funct3[1:0] == 2'b01)      addr_d[0]   = 1'b0;
    else if (req_funct3[1:0] == 2'b10) addr_d[1:0] = 2'b00;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_d;
        store_q <= req_store;
        f3_q    <= req_funct3;
        rd_q    <= req_rd;
        wdata_q <= req_wdata;
      end
      if ((state_q == S_WAIT) && mem_rvalid) ldata_q <= ldata_d;
    end
  end

  assign lane_data = 16'(mem_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  ldata_d = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  ldata_d = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  ldata_d = {24'h0, lane_data[7:0]};
      3'b101:  ldata_d = {16'h0, lane_data[15:0]};
      default: ldata_d = mem_rdata;
    endcase
  end

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = !legal ? S_SKIP : (trap ? S_EXC : S_REQ);
      end
      S_REQ: begin
        mem_re   = !store_q;
        mem_we   = store_q;
        mem_addr = addr_q[MEM_AW+1:2];
        if (store_q) begin
          case (f3_q[1:0])
            2'b00: begin
              mem_wstrb = 4'b0001 << addr_q[1:0];
              mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              mem_wstrb = 4'b0011 << addr_q[1:0];
              mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
              mem_wstrb = 4'b1111;
              mem_wdata = wdata_q;
            end
          endcase
        end
        if (mem_ready) state_d = store_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = ldata_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign exc_misaligned = (state_q == S_EXC);
  assign exc_addr       = exc_misaligned ? addr_q : 32'h0;
`else
  assign exc_misaligned = 1'b0;
  assign exc_addr       = 32'h0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:MEM_AW+2];
`endif

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Multi-cycle load/store unit on the memory side of the execute stage.
- Load/store ops are not computed by the combinational ALU; this block handles them. It takes base, offset and store data from execute, forms the byte address, and runs a valid/ready handshake with word-addressed data memory.
- Loads are returned to writeback sign- or zero-extended.
- Stores are issued with per-byte write strobes.

Parameters:
- MEM_AW, 15: data-memory word-address width; mem_addr = byte_addr[MEM_AW+1:2].

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-high (1 = reset)
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU can accept an op (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
- req_base  in  32  rs1 value
- req_imm  in  32  sign-extended offset
- req_wdata  in  32  rs2 value (store data)
- req_rd  in  5  load destination register
- mem_re  out  1  read request
- mem_we  out  1  write request
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables; bit i = byte lane i
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse with load result
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- exc_misaligned  out  1  one-cycle pulse, misaligned access
- exc_addr  out  32  faulting byte address

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state IDLE.
- Address: byte_addr = req_base + req_imm, mod 2^32, wrap-around allowed. Latched with op, funct3, rd, wdata on accept (req_valid && req_ready).
- States:
  - IDLE → REQ on accept.
  - REQ: mem_re or mem_we held high, mem_addr/wdata/wstrb stable, until mem_ready. Store → IDLE. Load → WAIT.
  - WAIT: wait for mem_rvalid (earliest the cycle after mem_ready) → RESP.
  - RESP: wb_valid = 1 for exactly one cycle → IDLE.
- Latency: request visible the cycle after accept. With zero-wait memory (mem_ready same cycle, mem_rvalid next cycle), wb_valid is 3 cycles after accept. Store back-to-back throughput: 1 op per 2 cycles.
- Store lanes, with lane = byte_addr[1:0]:
  - SB: wstrb = 1 << lane; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << lane; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata = wdata.
- Load extract: byte/half selected by lane from mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Undefined funct3 (011, 110, 111): no memory access, no wb, no exception; return to IDLE after one cycle.
- mem_rvalid outside WAIT is ignored. mem_ready outside REQ is ignored.
- Reset in any state: immediate return to IDLE. In-flight request dropped; mem_re/mem_we fall to 0 next edge. Late mem_rvalid produces no wb.
- Loads with req_rd = 0 still access memory and pulse wb_valid, with wb_rd = 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with byte_addr[0] = 1, or LW/SW with byte_addr[1:0] != 0, perform no memory access. exc_misaligned pulses 1 cycle after accept, exc_addr = byte_addr, then IDLE; no wb_valid.
- Undefined: exc_misaligned/exc_addr are tied 0. Low address bits are forced aligned (half: bit0 = 0; word: bits[1:0] = 0) and the access proceeds normally.

Test Plan:
- LW, base=0x100, imm=0x4, zero-wait memory returns 0xDEADBEEF → mem_addr = 0x41, mem_re for 1 cycle, wb_valid 3 cycles after accept, wb_data = 0xDEADBEEF.
- LB/LBU at byte_addr 0x103, mem_rdata = 0x80FF_1234 → LB wb_data = 0xFFFFFF80; LBU wb_data = 0x00000080.
- SH at byte_addr 0x202, rs2 = 0x0000ABCD → mem_we, mem_addr = 0x80, mem_wstrb = 1100, mem_wdata = 0xABCDABCD; no wb_valid.
- mem_ready held low 5 cycles during LW → mem_re and mem_addr stable all 6 cycles; req_ready = 0 throughout.
- LW at byte_addr 0x102 → with LSU_MISALIGN_TRAP_EN: exc_misaligned pulse, exc_addr = 0x102, no mem_re. Without it: mem_addr = 0x40, normal load.
- Reset asserted during WAIT, mem_rvalid arrives the next cycle → no wb_valid; req_ready = 1 after the reset edge.
